// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the skid-buffered inter-stage registers.
//   mem_wb_payload_t : MEM/WB payload layout at the default configuration
//   skid_state_t     : occupancy state, bit0 = main valid, bit1 = skid valid
//   ZERO_REG         : architectural register hardwired to zero
package pipeline_pkg;

    localparam int unsigned DEF_XLEN    = 32;
    localparam int unsigned DEF_RADDR_W = 5;
    localparam int unsigned ZERO_REG    = 0;

    typedef struct packed {
        logic [DEF_XLEN-1:0]    alu_result;
        logic [DEF_XLEN-1:0]    read_data;
        logic                   mem_to_reg;
        logic                   reg_write;
        logic [DEF_RADDR_W-1:0] rd_num;
    } mem_wb_payload_t;

    // Encoding is the pair of entry valid bits {skid, main}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with synchronous flush.
//   clk, rst             : clock, async active-high reset
//   flush                : drop all entries next cycle (port handshakes still complete)
//   in_valid/in_ready    : upstream handshake; in_ready is a flop, independent of out_ready
//   in_data[W]           : upstream payload
//   out_valid/out_ready  : downstream handshake on the main entry
//   out_data[W]          : main entry payload, shown regardless of valid
module pipe_skid_buf
    import pipeline_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q;
    skid_state_t  state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    logic acc_c;
    logic ret_c;
    logic load_main_c;
    logic load_skid_c;
    logic pop_skid_c;

    // Both handshake outputs are straight state-register bits.
    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out_data  = main_q;

    assign acc_c = in_valid & in_ready;
    assign ret_c = out_valid & out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and entry load selects.
    always_comb begin
        state_d     = state_q;
        load_main_c = 1'b0;
        load_skid_c = 1'b0;
        pop_skid_c  = 1'b0;

        case (state_q)
            EMPTY: begin
                if (acc_c) begin
                    load_main_c = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (acc_c && ret_c) begin
                    load_main_c = 1'b1;
                end else if (acc_c) begin
                    load_skid_c = 1'b1;
                    state_d     = TWO;
                end else if (ret_c) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a retire can move the state.
                if (ret_c) begin
                    pop_skid_c = 1'b1;
                    state_d    = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush discards everything, including an entry accepted this cycle.
        if (flush) begin
            state_d     = EMPTY;
            load_main_c = 1'b0;
            load_skid_c = 1'b0;
            pop_skid_c  = 1'b0;
        end
    end

    // Entry payloads; only written on explicit loads, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_c) begin
                main_q <= in_data;
            end else if (pop_skid_c) begin
                main_q <= skid_q;
            end
            if (load_skid_c) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with valid/ready handshake and 2-entry skid buffer.
//   clk, rst                     : clock, async active-high reset
//   flush                        : synchronous pipeline flush
//   in_valid/in_ready            : upstream handshake
//   alu_result, read_data,
//   mem_to_reg, reg_write, rd_num: MEM-stage payload
//   out_valid/out_ready          : write-back handshake
//   *_out                        : head entry fields (qualify with out_valid)
//   wb_data                      : selected write-back value of the head entry
//   reg_write_out                : register write enable, gated by out_valid
//   retired_cnt                  : wrapping count of output handshakes
module mem_wb_skid_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned XLEN               = DEF_XLEN,
    parameter int unsigned RADDR_W            = DEF_RADDR_W,
    parameter bit          ZERO_REG_HARDWIRED = 1'b1,
    parameter int unsigned CNT_W              = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    alu_result,
    input  logic [XLEN-1:0]    read_data,
    input  logic               mem_to_reg,
    input  logic               reg_write,
    input  logic [RADDR_W-1:0] rd_num,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_result_out,
    output logic [XLEN-1:0]    read_data_out,
    output logic [XLEN-1:0]    wb_data,
    output logic               mem_to_reg_out,
    output logic               reg_write_out,
    output logic [RADDR_W-1:0] rd_num_out,
    output logic [CNT_W-1:0]   retired_cnt
);

    // Same field order as mem_wb_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0]    alu_result;
        logic [XLEN-1:0]    read_data;
        logic               mem_to_reg;
        logic               reg_write;
        logic [RADDR_W-1:0] rd_num;
    } stage_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(stage_payload_t);

    stage_payload_t         in_pl_c;
    stage_payload_t         head_c;
    logic [PAYLOAD_W-1:0]   head_bits;
    logic                   rd_is_zero_c;
    logic [CNT_W-1:0]       retired_q;

    assign rd_is_zero_c = (rd_num == RADDR_W'(ZERO_REG));

    // Capture-side payload; writes to the zero register are dropped here.
    always_comb begin
        in_pl_c            = '0;
        in_pl_c.alu_result = alu_result;
        in_pl_c.read_data  = read_data;
        in_pl_c.mem_to_reg = mem_to_reg;
        in_pl_c.reg_write  = reg_write & ~(ZERO_REG_HARDWIRED & rd_is_zero_c);
        in_pl_c.rd_num     = rd_num;
    end

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pl_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign head_c = head_bits;

    assign alu_result_out = head_c.alu_result;
    assign read_data_out  = head_c.read_data;
    assign mem_to_reg_out = head_c.mem_to_reg;
    assign rd_num_out     = head_c.rd_num;
    assign wb_data        = head_c.mem_to_reg ? head_c.read_data : head_c.alu_result;
    assign reg_write_out  = head_c.reg_write & out_valid;

    // Retired count; a retire in a flush cycle still counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else if (out_valid && out_ready) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign retired_cnt = retired_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
module tb_mem_wb_skid_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd_num;
    logic        out_ready;

    // Instance A: default configuration.
    logic        a_in_ready, a_out_valid, a_mem_to_reg_out, a_reg_write_out;
    logic [31:0] a_alu_result_out, a_read_data_out, a_wb_data;
    logic [4:0]  a_rd_num_out;
    logic [15:0] a_retired_cnt;

    // Instance B: zero register writable, 4-bit counter.
    logic        b_in_ready, b_out_valid, b_mem_to_reg_out, b_reg_write_out;
    logic [31:0] b_alu_result_out, b_read_data_out, b_wb_data;
    logic [4:0]  b_rd_num_out;
    logic [3:0]  b_retired_cnt;

    mem_wb_skid_stage dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .alu_result(alu_result), .read_data(read_data),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd_num(rd_num),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .alu_result_out(a_alu_result_out), .read_data_out(a_read_data_out),
        .wb_data(a_wb_data), .mem_to_reg_out(a_mem_to_reg_out),
        .reg_write_out(a_reg_write_out), .rd_num_out(a_rd_num_out),
        .retired_cnt(a_retired_cnt)
    );

    mem_wb_skid_stage #(
        .ZERO_REG_HARDWIRED(1'b0),
        .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .alu_result(alu_result), .read_data(read_data),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd_num(rd_num),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .alu_result_out(b_alu_result_out), .read_data_out(b_read_data_out),
        .wb_data(b_wb_data), .mem_to_reg_out(b_mem_to_reg_out),
        .reg_write_out(b_reg_write_out), .rd_num_out(b_rd_num_out),
        .retired_cnt(b_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of held entries (capacity 2) plus a retire count.
    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdat;
        logic        mtr;
        logic        rw;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];
    int   cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            bit acc, ret;
            ent_t e;
            acc = in_valid && (q.size() < 2);
            ret = (q.size() > 0) && out_ready;
            if (ret) begin
                void'(q.pop_front());
                cnt++;
            end
            if (acc) begin
                e.alu  = alu_result;
                e.rdat = read_data;
                e.mtr  = mem_to_reg;
                e.rw   = reg_write;
                e.rd   = rd_num;
                q.push_back(e);
            end
            if (flush) q.delete();
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        ent_t h;
        chk("a_out_valid", 64'(a_out_valid), 64'(q.size() > 0));
        chk("a_in_ready",  64'(a_in_ready),  64'(q.size() < 2));
        chk("b_out_valid", 64'(b_out_valid), 64'(q.size() > 0));
        chk("b_in_ready",  64'(b_in_ready),  64'(q.size() < 2));
        chk("a_retired_cnt", 64'(a_retired_cnt), 64'(cnt % 65536));
        chk("b_retired_cnt", 64'(b_retired_cnt), 64'(cnt % 16));
        if (q.size() > 0) begin
            h = q[0];
            chk("a_alu_result_out", 64'(a_alu_result_out), 64'(h.alu));
            chk("a_read_data_out",  64'(a_read_data_out),  64'(h.rdat));
            chk("a_mem_to_reg_out", 64'(a_mem_to_reg_out), 64'(h.mtr));
            chk("a_rd_num_out",     64'(a_rd_num_out),     64'(h.rd));
            chk("a_wb_data",        64'(a_wb_data),        64'(h.mtr ? h.rdat : h.alu));
            chk("a_reg_write_out",  64'(a_reg_write_out),  64'(h.rw && (h.rd != 5'd0)));
            chk("b_wb_data",        64'(b_wb_data),        64'(h.mtr ? h.rdat : h.alu));
            chk("b_reg_write_out",  64'(b_reg_write_out),  64'(h.rw));
        end else begin
            chk("a_reg_write_out_idle", 64'(a_reg_write_out), 64'd0);
            chk("b_reg_write_out_idle", 64'(b_reg_write_out), 64'd0);
        end
    end

    task automatic set_in(input logic iv, input logic [31:0] alu, input logic [31:0] rdat,
                          input logic mtr, input logic rw, input logic [4:0] rd,
                          input logic ordy, input logic fl);
        in_valid   = iv;
        alu_result = alu;
        read_data  = rdat;
        mem_to_reg = mtr;
        reg_write  = rw;
        rd_num     = rd;
        out_ready  = ordy;
        flush      = fl;
    endtask

    // Advance one clock; returns with outputs settled after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid",  64'(a_out_valid), 64'd0);
        chk("rst_in_ready",   64'(a_in_ready), 64'd1);
        chk("rst_wb_data",    64'(a_wb_data), 64'd0);
        chk("rst_rd_num_out", 64'(a_rd_num_out), 64'd0);
        chk("rst_mtr_out",    64'(a_mem_to_reg_out), 64'd0);
        chk("rst_cnt",        64'(a_retired_cnt), 64'd0);
        rst = 1'b0;

        // Streaming at full throughput.
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'(i), 32'hDEAD_0000 + 32'(i), 1'b0, 1'b1, 5'(i + 1), 1'b1, 1'b0);
            tick();
            chk("stream_wb_data", 64'(a_wb_data), 64'(i));
            chk("stream_in_ready", 64'(a_in_ready), 64'd1);
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("stream_cnt", 64'(a_retired_cnt), 64'd8);

        // Backpressure into the skid entry.
        set_in(1'b1, 32'h11, 32'h0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
        tick();
        chk("bp_a_head", 64'(a_wb_data), 64'h11);
        set_in(1'b1, 32'h22, 32'h0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
        tick();
        chk("bp_full_in_ready", 64'(a_in_ready), 64'd0);
        set_in(1'b1, 32'h33, 32'h0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        tick();
        chk("bp_hold_head", 64'(a_wb_data), 64'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_b_head", 64'(a_wb_data), 64'h22);
        tick();
        chk("bp_c_head", 64'(a_wb_data), 64'h33);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("bp_cnt", 64'(a_retired_cnt), 64'd11);

        // Zero-register write suppression.
        set_in(1'b1, 32'h5, 32'h0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        chk("zr_a_rd0", 64'(a_reg_write_out), 64'd0);
        chk("zr_b_rd0", 64'(b_reg_write_out), 64'd1);
        set_in(1'b1, 32'h6, 32'h0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        tick();
        chk("zr_a_rd3", 64'(a_reg_write_out), 64'd1);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();

        // Write-back mux.
        set_in(1'b1, 32'hAAAA_0000, 32'h5555_FFFF, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        tick();
        chk("mux_mem", 64'(a_wb_data), 64'h5555_FFFF);
        mem_to_reg = 1'b0;
        tick();
        chk("mux_alu", 64'(a_wb_data), 64'hAAAA_0000);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("mux_cnt", 64'(a_retired_cnt), 64'd15);

        // Flush with both entries full and a push in the same cycle.
        set_in(1'b1, 32'h41, 32'h0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        alu_result = 32'h42;
        tick();
        set_in(1'b1, 32'h43, 32'h0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        tick();
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_in_ready",  64'(a_in_ready), 64'd1);
        chk("flush_cnt",       64'(a_retired_cnt), 64'd15);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();

        // Counter wrap on the 4-bit instance.
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            set_in(1'b1, 32'(100 + i), 32'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        chk("wrap_a_cnt", 64'(a_retired_cnt), 64'd17);
        chk("wrap_b_cnt", 64'(b_retired_cnt), 64'd1);

        // Randomised traffic with backpressure and occasional flush.
        for (int i = 0; i < 500; i++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            tick();
        end

        // Asynchronous reset while both entries are occupied.
        set_in(1'b1, 32'h77, 32'h0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        chk("pre_rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("pre_rst_cnt_nonzero", 64'(a_retired_cnt != 16'd0), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("async_rst_reg_write", 64'(a_reg_write_out), 64'd0);
        chk("async_rst_cnt",       64'(a_retired_cnt), 64'd0);
        chk("async_rst_in_ready",  64'(a_in_ready), 64'd1);
        chk("async_rst_wb_data",   64'(a_wb_data), 64'd0);
        tick();
        rst = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
